// File: rtl/rr_channel_fifo_if.sv
// Bus bundle for rr_channel_fifo: per-channel push side, shared pop side and
// the per-channel occupancy / almost-full status.
interface rr_channel_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CH    = 4
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(CH);

    logic [CH-1:0]       i_push_valid;
    logic [CH*WIDTH-1:0] i_push_data;
    logic [CH-1:0]       o_push_ready;
    logic                o_pop_valid;
    logic [WIDTH-1:0]    o_pop_data;
    logic [IW-1:0]       o_pop_ch;
    logic                i_pop_ready;
    logic [CH*CW-1:0]    o_count;
    logic [CH-1:0]       o_almost_full;

    // FIFO side
    modport slave (
        input  i_push_valid, i_push_data, i_pop_ready,
        output o_push_ready, o_pop_valid, o_pop_data, o_pop_ch, o_count, o_almost_full
    );

    // Producer / consumer side
    modport master (
        output i_push_valid, i_push_data, i_pop_ready,
        input  o_push_ready, o_pop_valid, o_pop_data, o_pop_ch, o_count, o_almost_full
    );
endinterface

// File: rtl/rr_channel_fifo.sv
// Multi-channel FIFO: CH independent DEPTH-entry queues merged onto a single
// pop port by a round-robin arbiter whose grant is held while the consumer stalls.
module rr_channel_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int CH        = 4,
    parameter int AF_THRESH = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    rr_channel_fifo_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(CH);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q    [CH][DEPTH];
    logic [PW-1:0]    wr_ptr_q [CH];
    logic [PW-1:0]    wr_ptr_d [CH];
    logic [PW-1:0]    rd_ptr_q [CH];
    logic [PW-1:0]    rd_ptr_d [CH];
    logic [CW-1:0]    count_q  [CH];
    logic [CW-1:0]    count_d  [CH];
    logic [IW-1:0]    rr_q, rr_d;
    logic             lock_q, lock_d;
    logic [IW-1:0]    lock_ch_q, lock_ch_d;

    logic [CH-1:0]    nonempty;
    logic [CH-1:0]    push_ready;
    logic [CH-1:0]    push_hs;
    logic             pop_valid;
    logic             pop_hs;
    logic [IW-1:0]    grant;
    logic [IW-1:0]    cand;
    logic             found;
    logic [WIDTH-1:0] pop_data;

    // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two)
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Channel index advance with wrap at CH-1
    function automatic logic [IW-1:0] ch_inc(input logic [IW-1:0] c);
        return (c == IW'(CH - 1)) ? '0 : c + 1'b1;
    endfunction

    // Per-channel status derived from registered occupancy
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            nonempty[c]   = (count_q[c] != '0);
            push_ready[c] = (count_q[c] != CW'(DEPTH));
            push_hs[c]    = bus.i_push_valid[c] & push_ready[c];
        end
    end

    // Grant: held channel while locked, else first non-empty from rr pointer
    always_comb begin
        grant = '0;
        cand  = '0;
        found = 1'b0;
        if (lock_q) begin
            grant = lock_ch_q;
        end else begin
            for (int i = 0; i < CH; i++) begin
                cand = IW'((int'(rr_q) + i) % CH);
                if (!found && nonempty[cand]) begin
                    found = 1'b1;
                    grant = cand;
                end
            end
        end
    end

    assign pop_valid = |nonempty;
    assign pop_hs    = pop_valid & bus.i_pop_ready;
    // Gate with valid so the unreset storage never leaks onto the port
    assign pop_data  = pop_valid ? mem_q[grant][rd_ptr_q[grant]] : '0;

    // Next-state for pointers, counts, rr pointer and grant lock
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            logic pop_c;
            pop_c       = pop_hs && (grant == IW'(c));
            wr_ptr_d[c] = push_hs[c] ? ptr_inc(wr_ptr_q[c]) : wr_ptr_q[c];
            rd_ptr_d[c] = pop_c ? ptr_inc(rd_ptr_q[c]) : rd_ptr_q[c];
            count_d[c]  = count_q[c];
            if (push_hs[c] && !pop_c) begin
                count_d[c] = count_q[c] + 1'b1;
            end else if (!push_hs[c] && pop_c) begin
                count_d[c] = count_q[c] - 1'b1;
            end
        end
        rr_d      = pop_hs ? ch_inc(grant) : rr_q;
        lock_d    = pop_valid & ~bus.i_pop_ready;
        lock_ch_d = grant;
    end

    // Control state register with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
            rr_q      <= '0;
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    // Entry storage, not reset; writes suppressed in the reset cycle
    always_ff @(posedge i_clk) begin
        for (int c = 0; c < CH; c++) begin
            if (push_hs[c] && !i_rst) begin
                mem_q[c][wr_ptr_q[c]] <= bus.i_push_data[c*WIDTH +: WIDTH];
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_status
        assign bus.o_count[g*CW +: CW] = count_q[g];
        assign bus.o_almost_full[g]    = (count_q[g] >= CW'(AF_THRESH));
    end

    assign bus.o_push_ready = push_ready;
    assign bus.o_pop_valid  = pop_valid;
    assign bus.o_pop_data   = pop_data;
    assign bus.o_pop_ch     = grant;
endmodule

// File: tb/tb_rr_channel_fifo.sv
// Directed testbench for rr_channel_fifo (CH=4, WIDTH=8, DEPTH=4, AF_THRESH=3).
module tb_rr_channel_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CH    = 4;
    localparam int CW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    rr_channel_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CH(CH)) bus ();

    rr_channel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CH(CH), .AF_THRESH(3)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_push_valid = '0;
        bus.i_push_data  = '0;
        bus.i_pop_ready  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [CW-1:0] cnt(input int c);
        return bus.o_count[c*CW +: CW];
    endfunction

    task automatic set_data(input int c, input logic [7:0] d);
        bus.i_push_data[c*WIDTH +: WIDTH] = d;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        tests++; if (bus.o_push_ready !== 4'hF) begin fails++; $display("FAIL reset_push_ready got %h exp f", bus.o_push_ready); end
        tests++; if (bus.o_pop_valid !== 1'b0) begin fails++; $display("FAIL reset_pop_valid got %b exp 0", bus.o_pop_valid); end
        tests++; if (bus.o_pop_ch !== 2'd0) begin fails++; $display("FAIL reset_pop_ch got %0d exp 0", bus.o_pop_ch); end
        tests++; if (bus.o_pop_data !== 8'h00) begin fails++; $display("FAIL reset_pop_data got %h exp 00", bus.o_pop_data); end
        tests++; if (bus.o_count !== 12'h000) begin fails++; $display("FAIL reset_count got %h exp 000", bus.o_count); end
        tests++; if (bus.o_almost_full !== 4'h0) begin fails++; $display("FAIL reset_af got %h exp 0", bus.o_almost_full); end
    endtask

    task automatic test_single_push();
        do_reset();
        bus.i_push_valid = 4'b0100;
        set_data(2, 8'hA0);
        bus.i_pop_ready = 1'b1;
        step();
        idle_inputs();
        bus.i_pop_ready = 1'b1;
        tests++; if (bus.o_pop_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b exp 1", bus.o_pop_valid); end
        tests++; if (bus.o_pop_ch !== 2'd2) begin fails++; $display("FAIL single_ch got %0d exp 2", bus.o_pop_ch); end
        tests++; if (bus.o_pop_data !== 8'hA0) begin fails++; $display("FAIL single_data got %h exp a0", bus.o_pop_data); end
        tests++; if (cnt(2) !== 3'd1) begin fails++; $display("FAIL single_count got %0d exp 1", cnt(2)); end
        step();
        tests++; if (bus.o_pop_valid !== 1'b0) begin fails++; $display("FAIL single_empty got %b exp 0", bus.o_pop_valid); end
        tests++; if (bus.o_count !== 12'h000) begin fails++; $display("FAIL single_count0 got %h exp 000", bus.o_count); end
    endtask

    task automatic test_fill();
        logic [2:0] exp_cnt;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            bus.i_push_valid = 4'b0001;
            set_data(0, 8'(8'h10 + k));
            step();
            exp_cnt = (k < 4) ? 3'(k + 1) : 3'd4;
            tests++; if (cnt(0) !== exp_cnt) begin fails++; $display("FAIL fill_count[%0d] got %0d exp %0d", k, cnt(0), exp_cnt); end
            tests++; if (bus.o_almost_full[0] !== (k >= 2)) begin fails++; $display("FAIL fill_af[%0d] got %b exp %b", k, bus.o_almost_full[0], (k >= 2)); end
            tests++; if (bus.o_push_ready[0] !== (k < 3)) begin fails++; $display("FAIL fill_ready[%0d] got %b exp %b", k, bus.o_push_ready[0], (k < 3)); end
        end
        idle_inputs();
        bus.i_pop_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tests++; if (bus.o_pop_valid !== 1'b1 || bus.o_pop_data !== 8'(8'h10 + k)) begin fails++; $display("FAIL fill_pop[%0d] got v=%b d=%h exp v=1 d=%h", k, bus.o_pop_valid, bus.o_pop_data, 8'(8'h10 + k)); end
            step();
        end
        tests++; if (bus.o_pop_valid !== 1'b0 || cnt(0) !== 3'd0) begin fails++; $display("FAIL fill_drained got v=%b c=%0d exp v=0 c=0", bus.o_pop_valid, cnt(0)); end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.i_push_valid = 4'hF;
        bus.i_push_data  = 32'h03020100;
        step();
        idle_inputs();
        bus.i_pop_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tests++; if (bus.o_pop_ch !== 2'(k) || bus.o_pop_data !== 8'(k)) begin fails++; $display("FAIL rr_grant[%0d] got ch=%0d d=%h exp ch=%0d d=%h", k, bus.o_pop_ch, bus.o_pop_data, k, 8'(k)); end
            step();
        end
        bus.i_pop_ready  = 1'b0;
        bus.i_push_valid = 4'b1001;
        set_data(0, 8'h20);
        set_data(3, 8'h23);
        step();
        idle_inputs();
        bus.i_pop_ready = 1'b1;
        tests++; if (bus.o_pop_ch !== 2'd0 || bus.o_pop_data !== 8'h20) begin fails++; $display("FAIL rr_refill0 got ch=%0d d=%h exp ch=0 d=20", bus.o_pop_ch, bus.o_pop_data); end
        step();
        tests++; if (bus.o_pop_ch !== 2'd3 || bus.o_pop_data !== 8'h23) begin fails++; $display("FAIL rr_refill3 got ch=%0d d=%h exp ch=3 d=23", bus.o_pop_ch, bus.o_pop_data); end
        step();
        tests++; if (bus.o_pop_valid !== 1'b0) begin fails++; $display("FAIL rr_empty got %b exp 0", bus.o_pop_valid); end
    endtask

    task automatic test_lock();
        do_reset();
        bus.i_push_valid = 4'b0010;
        set_data(1, 8'h41);
        step();
        idle_inputs();
        bus.i_push_valid = 4'b0001;
        set_data(0, 8'h40);
        for (int k = 0; k < 3; k++) begin
            tests++; if (bus.o_pop_ch !== 2'd1 || bus.o_pop_data !== 8'h41) begin fails++; $display("FAIL lock_hold[%0d] got ch=%0d d=%h exp ch=1 d=41", k, bus.o_pop_ch, bus.o_pop_data); end
            step();
            idle_inputs();
        end
        bus.i_pop_ready = 1'b1;
        tests++; if (bus.o_pop_ch !== 2'd1 || cnt(0) !== 3'd1) begin fails++; $display("FAIL lock_before_hs got ch=%0d c0=%0d exp ch=1 c0=1", bus.o_pop_ch, cnt(0)); end
        step();
        tests++; if (bus.o_pop_ch !== 2'd0 || bus.o_pop_data !== 8'h40) begin fails++; $display("FAIL lock_next got ch=%0d d=%h exp ch=0 d=40", bus.o_pop_ch, bus.o_pop_data); end
        tests++; if (cnt(1) !== 3'd0) begin fails++; $display("FAIL lock_count1 got %0d exp 0", cnt(1)); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_q [3];
        exp_q = '{8'h52, 8'h53, 8'h55};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bus.i_push_valid = 4'b0001;
            set_data(0, 8'(8'h50 + k));
            step();
        end
        tests++; if (bus.o_push_ready[0] !== 1'b0 || cnt(0) !== 3'd4) begin fails++; $display("FAIL fpp_full got r=%b c=%0d exp r=0 c=4", bus.o_push_ready[0], cnt(0)); end
        set_data(0, 8'h54);
        bus.i_pop_ready = 1'b1;
        tests++; if (bus.o_pop_data !== 8'h50) begin fails++; $display("FAIL fpp_head got %h exp 50", bus.o_pop_data); end
        step();
        tests++; if (cnt(0) !== 3'd3 || bus.o_push_ready[0] !== 1'b1) begin fails++; $display("FAIL fpp_after_full got c=%0d r=%b exp c=3 r=1", cnt(0), bus.o_push_ready[0]); end
        set_data(0, 8'h55);
        tests++; if (bus.o_pop_data !== 8'h51) begin fails++; $display("FAIL fpp_head2 got %h exp 51", bus.o_pop_data); end
        step();
        tests++; if (cnt(0) !== 3'd3) begin fails++; $display("FAIL fpp_count3 got %0d exp 3", cnt(0)); end
        bus.i_push_valid = '0;
        for (int k = 0; k < 3; k++) begin
            tests++; if (bus.o_pop_valid !== 1'b1 || bus.o_pop_data !== exp_q[k]) begin fails++; $display("FAIL fpp_drain[%0d] got v=%b d=%h exp v=1 d=%h", k, bus.o_pop_valid, bus.o_pop_data, exp_q[k]); end
            step();
        end
        tests++; if (bus.o_pop_valid !== 1'b0) begin fails++; $display("FAIL fpp_empty got %b exp 0", bus.o_pop_valid); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.i_push_valid = 4'b0010;
        set_data(1, 8'h61);
        step();
        idle_inputs();
        bus.i_pop_ready = 1'b1;
        step();
        idle_inputs();
        bus.i_push_valid = 4'b1011;
        bus.i_push_data  = 32'h63006260;
        step();
        idle_inputs();
        tests++; if (bus.o_pop_ch !== 2'd3) begin fails++; $display("FAIL mr_pre_grant got %0d exp 3", bus.o_pop_ch); end
        step();
        rst = 1'b1;
        bus.i_push_valid = 4'b0100;
        set_data(2, 8'h66);
        bus.i_pop_ready = 1'b1;
        step();
        rst = 1'b0;
        idle_inputs();
        tests++; if (bus.o_count !== 12'h000) begin fails++; $display("FAIL mr_count got %h exp 000", bus.o_count); end
        tests++; if (bus.o_pop_valid !== 1'b0) begin fails++; $display("FAIL mr_pop_valid got %b exp 0", bus.o_pop_valid); end
        tests++; if (bus.o_push_ready !== 4'hF) begin fails++; $display("FAIL mr_push_ready got %h exp f", bus.o_push_ready); end
        bus.i_push_valid = 4'b1010;
        bus.i_push_data  = 32'h73007100;
        step();
        idle_inputs();
        tests++; if (bus.o_pop_ch !== 2'd1 || bus.o_pop_data !== 8'h71) begin fails++; $display("FAIL mr_first_grant got ch=%0d d=%h exp ch=1 d=71", bus.o_pop_ch, bus.o_pop_data); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_push();
        test_fill();
        test_round_robin();
        test_lock();
        test_full_push_pop();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
